// File: rtl/jtag_uart_stream_master.sv
// Avalon-MM master for the JTAG UART: polls RX into a byte stream and writes TX bytes under a WSPACE credit.
// Optional JTAG_STREAM_CRLF_EN expands each TX 0x0A into a 0x0D, 0x0A write pair.
module jtag_uart_stream_master #(
  parameter int unsigned POLL_CYCLES = 256,
  parameter int unsigned CREDIT_W    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                av_address,
  output logic                av_chipselect,
  output logic                av_read_n,
  output logic                av_write_n,
  output logic [31:0]         av_writedata,
  input  logic [31:0]         av_readdata,
  input  logic                av_waitrequest,
  input  logic [7:0]          tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES + 1) : 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(64);

  typedef enum logic [2:0] {IDLE, RD_DATA, RD_CTRL, WR_DATA, WAIT_POLL} state_t;

  state_t            state, state_nxt;
  logic [POLL_W-1:0] poll_cnt;
  logic              last_tx;
  logic              done;
  logic              tx_req, rx_req, grant_tx;
  logic [7:0]        wr_byte;
  logic              wr_last;
  logic              rd_unused;

  assign done      = !av_waitrequest;
  assign tx_req    = tx_valid;
  assign rx_req    = !rx_valid && (poll_cnt == '0);
  assign grant_tx  = tx_req && (!rx_req || !last_tx);
  assign rd_unused = ^av_readdata[14:8];

`ifdef JTAG_STREAM_CRLF_EN
  logic cr_pend;
  logic lf_expand;

  // A 0x0A not yet preceded by its CR goes out as 0x0D first; the byte stays unacknowledged.
  assign lf_expand = (tx_data == 8'h0A) && !cr_pend;
  assign wr_byte   = lf_expand ? 8'h0D : tx_data;
  assign wr_last   = !lf_expand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cr_pend <= 1'b0;
    else if (state == WR_DATA && done)
      cr_pend <= lf_expand;
  end
`else
  assign wr_byte = tx_data;
  assign wr_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Bus outputs decode from state only, so an async reset drops the strobes at once.
  always_comb begin
    state_nxt     = state;
    av_address    = 1'b0;
    av_chipselect = 1'b0;
    av_read_n     = 1'b1;
    av_write_n    = 1'b1;
    av_writedata  = '0;
    tx_ready      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_tx)
          state_nxt = (credit != '0) ? WR_DATA : RD_CTRL;
        else if (rx_req)
          state_nxt = RD_DATA;
      end
      RD_DATA: begin
        av_chipselect = 1'b1;
        av_read_n     = 1'b0;
        if (done)
          state_nxt = av_readdata[15] ? IDLE : WAIT_POLL;
      end
      RD_CTRL: begin
        av_chipselect = 1'b1;
        av_read_n     = 1'b0;
        av_address    = 1'b1;
        if (done)
          state_nxt = IDLE;
      end
      WR_DATA: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_writedata  = {24'h000000, wr_byte};
        if (done) begin
          tx_ready  = wr_last;
          state_nxt = IDLE;
        end
      end
      WAIT_POLL: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_tx <= 1'b0;
    else if (state == IDLE && grant_tx)
      last_tx <= 1'b1;
    else if (state == IDLE && rx_req)
      last_tx <= 1'b0;
  end

  // The counter runs down in every state, so TX keeps flowing while RX polls are held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      poll_cnt <= '0;
    else if (state == RD_DATA && done && !av_readdata[15])
      poll_cnt <= POLL_W'(POLL_CYCLES);
    else if (poll_cnt != '0)
      poll_cnt <= poll_cnt - POLL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (state == RD_DATA && done && av_readdata[15]) begin
      rx_data  <= av_readdata[7:0];
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      credit <= '0;
    else if (state == RD_CTRL && done)
      credit <= (av_readdata[31:16] > 16'd64) ? CREDIT_MAX : CREDIT_W'(av_readdata[31:16]);
    else if (state == WR_DATA && done)
      credit <= credit - CREDIT_W'(1);
  end

endmodule

// File: tb/tb_jtag_uart_stream_master.sv
// Scoreboard bench for jtag_uart_stream_master with a behavioural JTAG UART slave model.
`timescale 1ns/1ps
module tb_jtag_uart_stream_master;
  localparam int unsigned CREDIT_W = 7;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                av_address, av_chipselect, av_read_n, av_write_n;
  logic [31:0]         av_writedata;
  logic [31:0]         av_readdata = '0;
  logic                av_waitrequest = 1'b1;
  logic [7:0]          tx_data = '0;
  logic                tx_valid = 1'b0;
  logic                tx_ready;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready = 1'b0;
  logic [CREDIT_W-1:0] credit;

  always #5 clk = ~clk;

  jtag_uart_stream_master #(.POLL_CYCLES(256), .CREDIT_W(CREDIT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .av_address(av_address), .av_chipselect(av_chipselect),
    .av_read_n(av_read_n), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .credit(credit)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_wr_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  rx_fifo[$];
  logic [15:0] ctrl_q[$];
  logic [15:0] wspace = '0;
  logic        woverflow = 1'b0;
  int unsigned cycle = 0;
  int unsigned wr_cnt = 0, ctrl_rd_cnt = 0, data_rd_cnt = 0, tx_rdy_cnt = 0, wr_at_ctrl = 0;
  int unsigned last_rd_t = 0, prev_rd_t = 0;
  bit          prev_done = 1'b0;
  logic        slv_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Slave: waitrequest idles high and drops for one cycle per request.
  assign slv_req = av_chipselect && (!av_read_n || !av_write_n);

  always @(posedge clk) begin
    logic [15:0] ws;
    cycle <= cycle + 1;
    if (slv_req && av_waitrequest) begin
      av_waitrequest <= 1'b0;
      if (!av_read_n) begin
        if (av_address) begin
          ws = (ctrl_q.size() > 0) ? ctrl_q.pop_front() : wspace;
          wspace      <= ws;
          av_readdata <= {ws, 16'h0000};
        end else if (rx_fifo.size() > 0) begin
          av_readdata <= {16'(rx_fifo.size() - 1), 8'h80, rx_fifo[0]};
        end else begin
          av_readdata <= '0;
        end
      end
    end else begin
      av_waitrequest <= 1'b1;
    end
    if (slv_req && !av_waitrequest) begin
      if (!av_write_n && !av_address) begin
        if (wspace == 16'd0) woverflow <= 1'b1;
        else                 wspace    <= wspace - 16'd1;
      end
      if (!av_read_n && !av_address && rx_fifo.size() > 0)
        void'(rx_fifo.pop_front());
    end
  end

  // Monitor: observes completed transfers and stream handshakes mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done)
        check("idle_after_xfer", {29'd0, av_chipselect, av_read_n, av_write_n}, 32'h3);
      prev_done = slv_req && !av_waitrequest;
      if (slv_req && !av_waitrequest) begin
        if (!av_write_n) begin
          wr_cnt++;
          if (exp_wr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: actual=0x%0h required=no write", av_writedata);
          end else begin
            check("wr_data", av_writedata, {24'h000000, exp_wr_q.pop_front()});
          end
        end else if (av_address) begin
          ctrl_rd_cnt++;
          wr_at_ctrl = wr_cnt;
        end else begin
          data_rd_cnt++;
          prev_rd_t = last_rd_t;
          last_rd_t = cycle;
        end
      end
      if (tx_ready) tx_rdy_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_rx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rx: actual=0x%0h required=no byte", rx_data);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx_q.pop_front()});
        end
      end
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned t;
    t = 0;
`ifdef JTAG_STREAM_CRLF_EN
    if (b == 8'h0A) exp_wr_q.push_back(8'h0D);
`endif
    exp_wr_q.push_back(b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_accept_timeout: actual=no tx_ready required=tx_ready within 3000 cycles");
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_wr_empty(input string name);
    int unsigned t;
    t = 0;
    while (exp_wr_q.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(exp_wr_q.size()), 32'd0);
  endtask

  initial begin
    int unsigned w0, c0, t0, r0, tmo;
    #500_000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned w0, c0, t0, r0, tmo;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_chipselect", {31'd0, av_chipselect}, 32'd0);
    check("rst_read_n",     {31'd0, av_read_n},     32'd1);
    check("rst_write_n",    {31'd0, av_write_n},    32'd1);
    check("rst_address",    {31'd0, av_address},    32'd0);
    check("rst_writedata",  av_writedata,           32'd0);
    check("rst_tx_ready",   {31'd0, tx_ready},      32'd0);
    check("rst_rx_valid",   {31'd0, rx_valid},      32'd0);
    check("rst_rx_data",    {24'd0, rx_data},       32'd0);
    check("rst_credit",     32'(credit),            32'd0);

    // Single byte: control read then one write, credit 64 -> 63
    ctrl_q.push_back(16'd64);
    w0 = wr_cnt; c0 = ctrl_rd_cnt; t0 = tx_rdy_cnt;
    rst_n = 1'b1;
    send_byte(8'h41);
    wait_wr_empty("t1_wr_drain");
    repeat (2) @(negedge clk);
    check("t1_credit",    32'(credit),           32'd63);
    check("t1_ctrl_rds",  ctrl_rd_cnt - c0,      32'd1);
    check("t1_writes",    wr_cnt - w0,           32'd1);
    check("t1_tx_ready_cycles", tx_rdy_cnt - t0, 32'd1);

    // 70 bytes against WSPACE 64 then 10
    ctrl_q.push_back(16'd64);
    ctrl_q.push_back(16'd10);
    do_reset();
    w0 = wr_cnt; c0 = ctrl_rd_cnt;
    for (int i = 0; i < 70; i++) send_byte(8'(8'h20 + i));
    wait_wr_empty("t2_wr_drain");
    repeat (2) @(negedge clk);
    check("t2_writes",          wr_cnt - w0,      32'd70);
    check("t2_ctrl_rds",        ctrl_rd_cnt - c0, 32'd2);
    check("t2_writes_before_2nd_ctrl", wr_at_ctrl - w0, 32'd64);
    check("t2_credit",          32'(credit),      32'd4);
    check("t2_woverflow",       {31'd0, woverflow}, 32'd0);

    // RX holding register with a stalled consumer
    rx_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_fifo.push_back(8'h55);
    rx_fifo.push_back(8'h66);
    exp_rx_q.push_back(8'h55);
    exp_rx_q.push_back(8'h66);
    r0 = data_rd_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_rx_valid_held", {31'd0, rx_valid}, 32'd1);
    check("t3_rx_data_held",  {24'd0, rx_data},  32'h55);
    check("t3_one_data_read", data_rd_cnt - r0,  32'd1);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    tmo = 0;
    while (exp_rx_q.size() > 0 && tmo < 2000) begin
      @(negedge clk);
      tmo++;
    end
    check("t3_rx_drained", 32'(exp_rx_q.size()), 32'd0);

    // Empty RX: polls spaced by POLL_CYCLES, TX flows in the gap
    ctrl_q.push_back(16'd64);
    r0 = data_rd_cnt;
    tmo = 0;
    while (data_rd_cnt == r0 && tmo < 600) begin
      @(negedge clk);
      tmo++;
    end
    check("t4_first_poll_seen", {31'd0, tmo < 600}, 32'd1);
    r0 = data_rd_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i));
    wait_wr_empty("t4_wr_drain");
    check("t4_writes_in_gap", wr_cnt - w0,      32'd5);
    check("t4_no_poll_in_gap", data_rd_cnt - r0, 32'd0);
    tmo = 0;
    while (data_rd_cnt == r0 && tmo < 600) begin
      @(negedge clk);
      tmo++;
    end
    check("t4_second_poll_seen", {31'd0, tmo < 600}, 32'd1);
    if (last_rd_t - prev_rd_t < 257)
      $display("poll spacing observed: %0d cycles", last_rd_t - prev_rd_t);
    check("t4_poll_spacing_ge_257", {31'd0, (last_rd_t - prev_rd_t) >= 257}, 32'd1);

    // Reset during the stall cycle of a write
    w0 = wr_cnt; t0 = tx_rdy_cnt;
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    tmo = 0;
    @(negedge clk);
    while (!(!av_write_n && av_waitrequest) && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    check("t5_write_started", {31'd0, tmo < 100}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_cs_dropped",      {31'd0, av_chipselect}, 32'd0);
    check("t5_write_n_dropped", {31'd0, av_write_n},    32'd1);
    check("t5_tx_ready_low",    {31'd0, tx_ready},      32'd0);
    tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_credit_after",   32'(credit),       32'd0);
    check("t5_no_write_done",  wr_cnt - w0,       32'd0);
    check("t5_no_tx_ready",    tx_rdy_cnt - t0,   32'd0);

    // 0x0A with WSPACE 100 (saturates to 64)
    ctrl_q.push_back(16'd100);
    w0 = wr_cnt; t0 = tx_rdy_cnt;
    send_byte(8'h0A);
    wait_wr_empty("t6_wr_drain");
    repeat (2) @(negedge clk);
    check("t6_tx_ready_cycles", tx_rdy_cnt - t0, 32'd1);
`ifdef JTAG_STREAM_CRLF_EN
    check("t6_writes", wr_cnt - w0, 32'd2);
    check("t6_credit", 32'(credit), 32'd62);
`else
    check("t6_writes", wr_cnt - w0, 32'd1);
    check("t6_credit", 32'(credit), 32'd63);
`endif

    check("final_woverflow", {31'd0, woverflow}, 32'd0);
    check("final_rx_fifo",   32'(rx_fifo.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_uart_stream_master.md
Name: jtag_uart_stream_master

Overview:
- Avalon-MM master that sits directly in front of the JTAG UART slave and drives its 2-word register interface.
- Converts that register interface into two byte streams (valid/ready), so fabric logic (sensor framing, command parser) can send and receive console bytes without a Nios II in the loop.
- Polls the data register for RX bytes.
- Issues data writes for TX bytes, gated by a write-space credit read from the control register.

Parameters:
- POLL_CYCLES, 256, idle cycles between RX polls after a read returns RVALID=0; 0 means poll back-to-back.
- CREDIT_W, 7, width of the TX credit counter; must hold 64.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- av_address  out  1  0 = data register, 1 = control register
- av_chipselect  out  1  slave select
- av_read_n  out  1  read strobe, active-low
- av_write_n  out  1  write strobe, active-low
- av_writedata  out  32  write data; bits 7:0 carry the TX byte, all other bits are 0
- av_readdata  in  32  read data, valid in the cycle av_waitrequest=0
- av_waitrequest  in  1  slave stall
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted when tx_valid & tx_ready
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready
- credit  out  CREDIT_W  current TX credit, for debug

Behaviour:
- Reset values:
  - av_chipselect=0, av_read_n=1, av_write_n=1, av_address=0, av_writedata=0.
  - tx_ready=0, rx_valid=0, rx_data=0, credit=0.
  - FSM in IDLE; poll counter at 0.
- Bus rule:
  - Once chipselect and a strobe are asserted, address, data and strobe are held stable until the cycle av_waitrequest=0. That cycle completes the transfer.
  - All outputs return to idle on the next edge; there are no back-to-back strobes without one idle cycle.
  - The slave holds av_waitrequest=1 while idle and drops it for exactly one cycle per request, so the minimum transfer is 2 cycles.
- FSM states: IDLE, RD_DATA, RD_CTRL, WR_DATA, WAIT_POLL.
  - IDLE → WR_DATA when tx_valid=1 and credit>0.
  - IDLE → RD_CTRL when tx_valid=1 and credit=0.
  - IDLE → RD_DATA when the RX holding register is empty and the poll counter is 0.
  - When TX and RX requests coincide, arbitration is round-robin via a 1-bit last-served flag; TX is preferred after reset.
  - WR_DATA: tx_ready pulses high for exactly the completion cycle, consuming the byte; credit decrements; → IDLE.
  - RD_CTRL: on completion, credit ← av_readdata[31:16] saturated to 64 (WSPACE); → IDLE.
  - RD_DATA: on completion, if av_readdata[15]=1 (RVALID), rx_data ← readdata[7:0], rx_valid ← 1, → IDLE. Otherwise the poll counter loads POLL_CYCLES, → WAIT_POLL.
  - WAIT_POLL: the counter decrements each cycle. A pending TX may still win in IDLE, because WAIT_POLL returns to IDLE every cycle while the counter is nonzero; only RD_DATA is blocked until the counter reaches 0.
- RX holding register:
  - One entry; no new RD_DATA is issued while rx_valid=1.
  - rx_valid clears on rx_valid & rx_ready.
  - If the handshake occurs in the same cycle as an RD_DATA completion, the new byte loads: the register is never lost or doubled.
- Credit:
  - Only refreshed by RD_CTRL; never exceeds 64.
  - Writes with credit=0 are never issued, so woverflow in the slave must never set.
- Reset mid-transfer: all strobes drop asynchronously, and the in-flight byte is neither acknowledged nor delivered.

Optional Feature:
- Macro JTAG_STREAM_CRLF_EN.
- Defined:
  - A TX byte 0x0A is expanded into two writes: 0x0D, then 0x0A.
  - A CR_PEND flag records the first write. tx_ready pulses only on completion of the 0x0A write, and each write consumes 1 credit.
  - The pair needs credit≥1 per write; a credit refresh may occur between them.
- Undefined: bytes are passed through unmodified, and no CR_PEND logic exists.

Test Plan:
- Reset, tx_valid=1 with tx_data=0x41, slave WSPACE=64 → one control read, then a data write with writedata=0x00000041; credit ends at 63; tx_ready is high exactly 1 cycle.
- 70 back-to-back TX bytes with the slave model reporting WSPACE=64 and then 10 → exactly 64 writes, a control read, then 6 more writes; woverflow is never set.
- Slave RX holds 0x55, 0x66; rx_ready=0 for 20 cycles → rx_data=0x55 held with exactly 1 data read issued; after rx_ready=1, 0x66 is delivered next.
- RX empty (RVALID=0), POLL_CYCLES=256 → consecutive data reads are spaced ≥257 cycles apart; TX writes proceed during the gap.
- rst_n asserted in the stall cycle of a write → strobes drop immediately, tx_ready stays 0, and credit=0 after release.
- With JTAG_STREAM_CRLF_EN, tx_data=0x0A → writes 0x0D then 0x0A, a single tx_ready pulse, and credit decremented by 2.
